// File: rtl/pts_wrapper.sv
// Parallel-to-serial converter: captures a 32-word frame in one cycle and streams it out word by word.
// Optional macro PTS_STATUS_EN adds the data_valid output backed by a words-remaining counter.
module pts_wrapper #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_strobe,
   input  logic             out_strobe,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [WIDTH-1:0] in4,
   input  logic [WIDTH-1:0] in5,
   input  logic [WIDTH-1:0] in6,
   input  logic [WIDTH-1:0] in7,
   input  logic [WIDTH-1:0] in8,
   input  logic [WIDTH-1:0] in9,
   input  logic [WIDTH-1:0] in10,
   input  logic [WIDTH-1:0] in11,
   input  logic [WIDTH-1:0] in12,
   input  logic [WIDTH-1:0] in13,
   input  logic [WIDTH-1:0] in14,
   input  logic [WIDTH-1:0] in15,
   input  logic [WIDTH-1:0] in16,
   input  logic [WIDTH-1:0] in17,
   input  logic [WIDTH-1:0] in18,
   input  logic [WIDTH-1:0] in19,
   input  logic [WIDTH-1:0] in20,
   input  logic [WIDTH-1:0] in21,
   input  logic [WIDTH-1:0] in22,
   input  logic [WIDTH-1:0] in23,
   input  logic [WIDTH-1:0] in24,
   input  logic [WIDTH-1:0] in25,
   input  logic [WIDTH-1:0] in26,
   input  logic [WIDTH-1:0] in27,
   input  logic [WIDTH-1:0] in28,
   input  logic [WIDTH-1:0] in29,
   input  logic [WIDTH-1:0] in30,
   input  logic [WIDTH-1:0] in31,
   input  logic [WIDTH-1:0] in32,
`ifdef PTS_STATUS_EN
   output logic             data_valid,
`endif
   output logic [WIDTH-1:0] serial_out
);

   logic [WIDTH-1:0] frame     [DEPTH];
   logic [WIDTH-1:0] shift_reg [DEPTH];

   assign frame[0]  = in1;
   assign frame[1]  = in2;
   assign frame[2]  = in3;
   assign frame[3]  = in4;
   assign frame[4]  = in5;
   assign frame[5]  = in6;
   assign frame[6]  = in7;
   assign frame[7]  = in8;
   assign frame[8]  = in9;
   assign frame[9]  = in10;
   assign frame[10] = in11;
   assign frame[11] = in12;
   assign frame[12] = in13;
   assign frame[13] = in14;
   assign frame[14] = in15;
   assign frame[15] = in16;
   assign frame[16] = in17;
   assign frame[17] = in18;
   assign frame[18] = in19;
   assign frame[19] = in20;
   assign frame[20] = in21;
   assign frame[21] = in22;
   assign frame[22] = in23;
   assign frame[23] = in24;
   assign frame[24] = in25;
   assign frame[25] = in26;
   assign frame[26] = in27;
   assign frame[27] = in28;
   assign frame[28] = in29;
   assign frame[29] = in30;
   assign frame[30] = in31;
   assign frame[31] = in32;

   // Load has priority over shift; zeros fill in behind the last word so over-reads return 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) shift_reg[i] <= '0;
      end else if (load_strobe) begin
         for (int i = 0; i < DEPTH; i++) shift_reg[i] <= frame[i];
      end else if (out_strobe) begin
         for (int i = 0; i < DEPTH - 1; i++) shift_reg[i] <= shift_reg[i+1];
         shift_reg[DEPTH-1] <= '0;
      end
   end

   assign serial_out = shift_reg[0];

`ifdef PTS_STATUS_EN
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load_strobe) begin
         cnt <= CNT_W'(DEPTH);
      end else if (out_strobe && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign data_valid = (cnt != '0);
`endif

endmodule

// File: tb/tb_pts_wrapper.sv
// Testbench for pts_wrapper: directed vector table, hand-written corner sequences and a randomized
// run checked against a queue-based frame model.
module tb_pts_wrapper;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_strobe = 1'b0;
   logic        out_strobe = 1'b0;
   logic [15:0] in_w [32];
   logic [15:0] serial_out;
   logic        dv;
   int          checks = 0;
   int          failures = 0;
   logic [15:0] model_q [$];

   always #5 clk = ~clk;

`ifdef PTS_STATUS_EN
   assign dv = dut.data_valid;
`else
   assign dv = 1'b0;
`endif

   pts_wrapper dut (
      .clk(clk), .rst(rst), .load_strobe(load_strobe), .out_strobe(out_strobe),
      .in1(in_w[0]),   .in2(in_w[1]),   .in3(in_w[2]),   .in4(in_w[3]),
      .in5(in_w[4]),   .in6(in_w[5]),   .in7(in_w[6]),   .in8(in_w[7]),
      .in9(in_w[8]),   .in10(in_w[9]),  .in11(in_w[10]), .in12(in_w[11]),
      .in13(in_w[12]), .in14(in_w[13]), .in15(in_w[14]), .in16(in_w[15]),
      .in17(in_w[16]), .in18(in_w[17]), .in19(in_w[18]), .in20(in_w[19]),
      .in21(in_w[20]), .in22(in_w[21]), .in23(in_w[22]), .in24(in_w[23]),
      .in25(in_w[24]), .in26(in_w[25]), .in27(in_w[26]), .in28(in_w[27]),
      .in29(in_w[28]), .in30(in_w[29]), .in31(in_w[30]), .in32(in_w[31]),
`ifdef PTS_STATUS_EN
      .data_valid(),
`endif
      .serial_out(serial_out)
   );

   typedef struct {
      bit          r;
      bit          l;
      bit          s;
      logic [15:0] base;
      logic [15:0] exp;
      bit          expv;
   } vec_t;

   vec_t vecs [$];

   task automatic set_frame(input logic [15:0] base);
      for (int i = 0; i < 32; i++) in_w[i] = base + 16'(i);
   endtask

   task automatic rand_frame();
      for (int i = 0; i < 32; i++) in_w[i] = 16'($urandom);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Drives one cycle, advances the frame model at the edge, then checks outputs.
   task automatic run(input bit r, input bit l, input bit s, input string name,
                      input logic [15:0] exp, input bit expv, input bit use_model);
      logic [15:0] e;
      bit          ev;
      rst = r; load_strobe = l; out_strobe = s;
      @(posedge clk);
      if (r) model_q.delete();
      else if (l) begin
         model_q.delete();
         for (int i = 0; i < 32; i++) model_q.push_back(in_w[i]);
      end else if (s && model_q.size() != 0) void'(model_q.pop_front());
      #1;
      e  = use_model ? ((model_q.size() != 0) ? model_q[0] : 16'h0) : exp;
      ev = use_model ? (model_q.size() != 0) : expv;
      chk(name, serial_out, e);
`ifdef PTS_STATUS_EN
      chk({name, "_valid"}, {15'h0, dv}, {15'h0, ev});
`else
      if (ev == dv) begin end
`endif
   endtask

   initial begin
      set_frame(16'h0);
      // Directed table: reset under load, full frame, over-read.
      vecs.push_back('{1, 1, 0, 16'hFFFF, 16'h0, 0});
      vecs.push_back('{1, 1, 0, 16'hFFFF, 16'h0, 0});
      vecs.push_back('{0, 1, 0, 16'h0000, 16'h0, 1});
      for (int k = 1; k < 32; k++) vecs.push_back('{0, 0, 1, 16'($urandom), 16'(k), 1});
      vecs.push_back('{0, 0, 1, 16'($urandom), 16'h0, 0});
      for (int k = 0; k < 3; k++) vecs.push_back('{0, 0, 1, 16'($urandom), 16'h0, 0});

      for (int i = 0; i < vecs.size(); i++) begin
         set_frame(vecs[i].base);
         run(vecs[i].r, vecs[i].l, vecs[i].s, $sformatf("vec%0d", i), vecs[i].exp, vecs[i].expv, 0);
      end

      // Hold with changing inputs.
      set_frame(16'h1234);
      run(0, 1, 0, "hold_load", 16'h1234, 1, 0);
      for (int k = 0; k < 10; k++) begin
         rand_frame();
         run(0, 0, 0, "hold", 16'h1234, 1, 0);
      end

      // Simultaneous strobes mid-stream: load wins.
      set_frame(16'h0);
      run(0, 1, 0, "sim_load", 16'h0, 1, 0);
      for (int k = 1; k <= 5; k++) begin
         rand_frame();
         run(0, 0, 1, "sim_pre", 16'(k), 1, 0);
      end
      set_frame(16'hA000);
      run(0, 1, 1, "sim_both", 16'hA000, 1, 0);
      rand_frame();
      run(0, 0, 1, "sim_next1", 16'hA001, 1, 0);
      run(0, 0, 1, "sim_next2", 16'hA002, 1, 0);

      // Reset mid-stream.
      set_frame(16'h0100);
      run(0, 1, 0, "rstm_load", 16'h0100, 1, 0);
      for (int k = 1; k <= 4; k++) run(0, 0, 1, "rstm_shift", 16'h0100 + 16'(k), 1, 0);
      run(1, 0, 0, "rstm_rst", 16'h0, 0, 0);
      for (int k = 0; k < 3; k++) run(0, 0, 1, "rstm_after", 16'h0, 0, 0);

      // Randomized run against the frame model.
      for (int k = 0; k < 600; k++) begin
         rand_frame();
         run(($urandom_range(49) == 0), ($urandom_range(11) == 0), ($urandom_range(1) == 0),
             "rand", 16'h0, 0, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
